// File: rtl/ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_prefetch
// Purpose  : Instruction prefetch queue with a decoupled memory request/response
//            interface, credit-limited sequential fetch and redirect flush.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_prefetch #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int              PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [ILEN-1:0] mem_rsp_data,
  input  logic            mem_rsp_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_inst,
  output logic            out_fault,
  output logic            busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 2;

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_req_addr;
  logic            r_req_pending;
  logic            r_req_stale;
  logic [AW:0]     r_alloc_ptr;
  logic [AW:0]     r_fill_ptr;
  logic [AW:0]     r_rd_ptr;
  logic [AW:0]     r_discard_cnt;

  logic [XLEN-1:0] r_q_pc   [DEPTH];
  logic [ILEN-1:0] r_q_inst [DEPTH];
  logic [DEPTH-1:0] r_q_fault;
  logic [DEPTH-1:0] r_q_filled;

  logic            w_accept;
  logic            w_accept_new;
  logic            w_accept_old;
  logic            w_pop;
  logic            w_rsp_drop;
  logic            w_rsp_fill;
  logic            w_credit;
  logic            w_raise;
  logic [AW:0]     w_live;
  logic [AW:0]     w_unfilled;
  logic [AW:0]     w_live_nx;
  logic [AW:0]     w_discard_nx;
  logic [XLEN-1:0] w_pc_src;
  logic [AW-1:0]   w_rd_idx;

  assign w_rd_idx     = r_rd_ptr[AW-1:0];
  assign w_accept     = r_req_pending && mem_req_ready;
  // A request accepted in the redirect cycle still belongs to the old stream.
  assign w_accept_old = w_accept && (r_req_stale || redirect_valid);
  assign w_accept_new = w_accept && !r_req_stale && !redirect_valid;
  assign w_pop        = out_valid && out_ready;
  assign w_rsp_drop   = mem_rsp_valid && (r_discard_cnt != '0);
  assign w_rsp_fill   = mem_rsp_valid && (r_discard_cnt == '0);
  assign w_live       = r_alloc_ptr - r_rd_ptr;
  assign w_unfilled   = r_alloc_ptr - r_fill_ptr;
  assign w_pc_src     = redirect_valid ? redirect_pc : r_fetch_pc;

  always_comb begin
    w_discard_nx = r_discard_cnt;
    w_live_nx    = w_live + (AW+1)'(w_accept_new) - (AW+1)'(w_pop);
    if (redirect_valid) begin
      // Every unfilled slot becomes a beat to throw away; a beat arriving now is
      // already one of them (or an earlier discard) and is consumed this cycle.
      w_discard_nx = r_discard_cnt + w_unfilled + (AW+1)'(w_accept_old)
                     - (AW+1)'(mem_rsp_valid);
      w_live_nx    = '0;
    end else begin
      w_discard_nx = r_discard_cnt + (AW+1)'(w_accept_old) - (AW+1)'(w_rsp_drop);
    end
  end

  // The new request takes one credit on top of everything still committed.
  assign w_credit = (CW'(w_live_nx) + CW'(w_discard_nx)) < CW'(DEPTH);
  assign w_raise  = (!r_req_pending || w_accept) && w_credit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_req_addr    <= RESET_PC;
      r_req_pending <= 1'b0;
      r_req_stale   <= 1'b0;
      r_discard_cnt <= '0;
    end else begin
      r_discard_cnt <= w_discard_nx;
      if (w_raise) begin
        r_req_pending <= 1'b1;
        r_req_addr    <= w_pc_src;
        r_fetch_pc    <= w_pc_src + XLEN'(PC_STEP);
        r_req_stale   <= 1'b0;
      end else begin
        if (w_accept) begin
          r_req_pending <= 1'b0;
          r_req_stale   <= 1'b0;
        end
        if (redirect_valid) begin
          r_fetch_pc <= redirect_pc;
          if (r_req_pending && !w_accept) r_req_stale <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_rd_ptr    <= '0;
      r_q_filled  <= '0;
    end else begin
      if (w_accept_new) r_alloc_ptr <= r_alloc_ptr + 1'b1;
      if (w_rsp_fill) begin
        r_q_filled[r_fill_ptr[AW-1:0]] <= 1'b1;
        r_fill_ptr                     <= r_fill_ptr + 1'b1;
      end
      if (w_pop) begin
        r_q_filled[w_rd_idx] <= 1'b0;
        r_rd_ptr             <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Payload storage carries no reset; validity lives in r_q_filled.
  always_ff @(posedge clk) begin
    if (w_accept_new) r_q_pc[r_alloc_ptr[AW-1:0]] <= r_req_addr;
    if (w_rsp_fill) begin
      r_q_inst[r_fill_ptr[AW-1:0]]  <= mem_rsp_data;
      r_q_fault[r_fill_ptr[AW-1:0]] <= mem_rsp_err;
    end
  end

  assign mem_req_valid = r_req_pending;
  assign mem_req_addr  = r_req_addr;
  assign out_valid     = r_q_filled[w_rd_idx];
  assign out_pc        = r_q_pc[w_rd_idx];
  assign out_inst      = r_q_inst[w_rd_idx];
  assign out_fault     = r_q_filled[w_rd_idx] & r_q_fault[w_rd_idx];
  assign busy          = r_req_pending || (r_discard_cnt != '0) || (w_unfilled != '0);

endmodule
`default_nettype wire

// File: tb/tb_ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_prefetch
// Purpose  : Self-checking bench for ifu_prefetch with an in-order memory model
//            and an expected-PC stream reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_prefetch;
  localparam int          DEPTH  = 4;
  localparam int          STEP   = 4;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_fault;
  logic        busy;

  ifu_prefetch #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(RST_PC), .PC_STEP(STEP)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_fault(out_fault), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] pop_log[$];
  logic        flt_log[$];
  logic [31:0] acc_log[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          req_pct = 100;
  int          out_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          err_hash = 1'b0;
  logic [31:0] err_addr = 32'h1;
  logic [31:0] exp_req, exp_out, prev_addr;
  bit          prev_hold, stale_held;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic err_of(input logic [31:0] pc);
    if (err_hash) return ((pc >> 2) % 5) == 2;
    return pc == err_addr;
  endfunction

  task automatic model_clear();
    mq.delete(); pop_log.delete(); flt_log.delete(); acc_log.delete();
    prev_hold = 1'b0; stale_held = 1'b0; last_due = 0;
    exp_req = RST_PC; exp_out = RST_PC;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  // One clock: drive memory/consumer, score the handshakes, advance the model.
  task automatic tick(input bit redir, input logic [31:0] rpc);
    bit          acc, pop, rsp;
    int          due;
    logic [31:0] acc_addr;
    redirect_valid = redir;
    redirect_pc    = rpc;
    mem_req_ready  = ($urandom_range(99) < req_pct);
    out_ready      = ($urandom_range(99) < out_pct);
    rsp = (mq.size() != 0) && (mq[0].due <= cyc);
    mem_rsp_valid = rsp;
    if (rsp) begin
      mem_rsp_data = inst_of(mq[0].addr);
      mem_rsp_err  = err_of(mq[0].addr);
    end else begin
      mem_rsp_data = $urandom;
      mem_rsp_err  = 1'($urandom_range(1));
    end
    acc      = mem_req_valid && mem_req_ready;
    pop      = out_valid && out_ready;
    acc_addr = mem_req_addr;
    if (prev_hold) begin
      n_chk++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== prev_addr) begin
        n_fail++;
        $display("FAIL req_hold valid=%b addr=%h, required valid=1 addr=%h", mem_req_valid, mem_req_addr, prev_addr);
      end
    end
    if (acc) begin
      n_chk++;
      if (mq.size() >= DEPTH) begin
        n_fail++;
        $display("FAIL outstanding %0d already in flight at accept, required < %0d", mq.size(), DEPTH);
      end
      if (!(stale_held || redir)) begin
        n_chk++;
        if (mem_req_addr !== exp_req) begin
          n_fail++;
          $display("FAIL req_addr got %h required %h", mem_req_addr, exp_req);
        end
        exp_req += STEP;
      end
      acc_log.push_back(mem_req_addr);
    end
    if (pop) begin
      n_chk++;
      if (out_pc !== exp_out || out_inst !== inst_of(exp_out) || out_fault !== err_of(exp_out)) begin
        n_fail++;
        $display("FAIL out_beat pc=%h inst=%h fault=%b, required pc=%h inst=%h fault=%b",
                 out_pc, out_inst, out_fault, exp_out, inst_of(exp_out), err_of(exp_out));
      end
      pop_log.push_back(out_pc);
      flt_log.push_back(out_fault);
      exp_out += STEP;
    end
    stale_held = mem_req_valid && !acc && (redir || stale_held);
    if (redir) begin
      exp_req = rpc;
      exp_out = rpc;
    end
    prev_hold = mem_req_valid && !mem_req_ready;
    prev_addr = mem_req_addr;
    @(posedge clk);
    #1;
    if (rsp) void'(mq.pop_front());
    if (acc) begin
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due < last_due) due = last_due;
      last_due = due;
      mq.push_back('{acc_addr, due});
    end
    cyc++;
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b required 0", busy); end
    n_chk++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got %b required 0", mem_req_valid); end
    n_chk++; if (out_fault !== 1'b0) begin n_fail++; $display("FAIL reset_out_fault got %b required 0", out_fault); end
    rst = 1'b0;
    model_clear();
    req_pct = 100; out_pct = 100; lat_min = 1; lat_max = 1;
    tick(1'b0, '0);
    n_chk++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL first_req valid=%b addr=%h required valid=1 addr=%h", mem_req_valid, mem_req_addr, RST_PC);
    end
  endtask

  task automatic test_stream();
    int n0;
    do_reset();
    req_pct = 100; out_pct = 100; lat_min = 1; lat_max = 1; err_hash = 1'b0; err_addr = 32'h1;
    repeat (20) tick(1'b0, '0);
    n0 = pop_log.size();
    repeat (20) tick(1'b0, '0);
    n_chk++;
    if (pop_log.size() - n0 != 20) begin
      n_fail++;
      $display("FAIL throughput got %0d pops in 20 cycles required 20", pop_log.size() - n0);
    end
    n_chk++;
    if (pop_log.size() < 3 || pop_log[0] !== RST_PC || pop_log[2] !== RST_PC + 32'd8) begin
      n_fail++;
      $display("FAIL stream_order first pops not 80000000/80000008 (count %0d)", pop_log.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req_pct = 100; out_pct = 0; lat_min = 1; lat_max = 1;
    repeat (20) tick(1'b0, '0);
    n_chk++;
    if (acc_log.size() != DEPTH) begin n_fail++; $display("FAIL bp_accepts got %0d required %0d", acc_log.size(), DEPTH); end
    n_chk++;
    if (mem_req_valid !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_stall req_valid=%b out_valid=%b required 0/1", mem_req_valid, out_valid);
    end
    out_pct = 100;
    repeat (12) tick(1'b0, '0);
    n_chk++;
    if (pop_log.size() < 4 || pop_log[3] !== RST_PC + 32'hC) begin
      n_fail++;
      $display("FAIL bp_release pops=%0d, fourth pop not 8000000c", pop_log.size());
    end
    n_chk++;
    if (acc_log.size() < 5 || acc_log[4] !== RST_PC + 32'h10) begin
      n_fail++;
      $display("FAIL bp_resume accepts=%0d, fifth request not 80000010", acc_log.size());
    end
  endtask

  task automatic test_redirect();
    int k;
    do_reset();
    req_pct = 100; out_pct = 100; lat_min = 5; lat_max = 5;
    k = 0;
    while (acc_log.size() < 3 && k < 20) begin tick(1'b0, '0); k++; end
    n_chk++;
    if (acc_log.size() < 3) begin n_fail++; $display("FAIL redir_setup accepts=%0d required 3", acc_log.size()); end
    pop_log.delete();
    tick(1'b1, 32'h8000_1000);
    n_chk++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_flush busy=%b out_valid=%b required 1/0", busy, out_valid);
    end
    repeat (30) tick(1'b0, '0);
    n_chk++;
    if (pop_log.size() == 0 || pop_log[0] !== 32'h8000_1000) begin
      n_fail++;
      $display("FAIL redir_first pops=%0d, first pop not 80001000", pop_log.size());
    end
  endtask

  task automatic test_held_redirect();
    int          k;
    logic [31:0] held;
    do_reset();
    req_pct = 0; out_pct = 100; lat_min = 2; lat_max = 2;
    k = 0;
    while (!mem_req_valid && k < 10) begin tick(1'b0, '0); k++; end
    n_chk++;
    if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL held_raise valid=%b required 1", mem_req_valid); end
    held = mem_req_addr;
    tick(1'b1, 32'h8000_2000);
    repeat (3) tick(1'b0, '0);
    n_chk++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== held) begin
      n_fail++;
      $display("FAIL held_addr valid=%b addr=%h required 1/%h", mem_req_valid, mem_req_addr, held);
    end
    req_pct = 100;
    repeat (20) tick(1'b0, '0);
    n_chk++;
    if (acc_log.size() < 2 || acc_log[0] !== held || acc_log[1] !== 32'h8000_2000) begin
      n_fail++;
      $display("FAIL held_sequence accepts=%0d, expected %h then 80002000", acc_log.size(), held);
    end
    n_chk++;
    if (pop_log.size() == 0 || pop_log[0] !== 32'h8000_2000) begin
      n_fail++;
      $display("FAIL held_first_pop pops=%0d, first pop not 80002000", pop_log.size());
    end
  endtask

  task automatic test_fault();
    int nf;
    do_reset();
    req_pct = 100; out_pct = 100; lat_min = 1; lat_max = 1; err_hash = 1'b0; err_addr = 32'h8000_0008;
    repeat (15) tick(1'b0, '0);
    nf = 0;
    foreach (flt_log[i]) if (flt_log[i]) nf++;
    n_chk++;
    if (flt_log.size() < 4 || nf != 1 || flt_log[2] !== 1'b1 || flt_log[1] !== 1'b0 || flt_log[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_flag faults=%0d of %0d pops, required exactly one at 80000008", nf, flt_log.size());
    end
    err_addr = 32'h1;
  endtask

  task automatic test_wrap();
    do_reset();
    req_pct = 100; out_pct = 100; lat_min = 1; lat_max = 2;
    tick(1'b1, 32'hFFFF_FFF8);
    repeat (15) tick(1'b0, '0);
    n_chk++;
    if (pop_log.size() < 3 || pop_log[0] !== 32'hFFFF_FFF8 || pop_log[2] !== 32'h0) begin
      n_fail++;
      $display("FAIL pc_wrap pops=%0d, sequence fffffff8.. not wrapping to 0", pop_log.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_pct = 100; out_pct = 0; lat_min = 3; lat_max = 3;
    repeat (6) tick(1'b0, '0);
    n_chk++;
    if (acc_log.size() != DEPTH || mq.size() != 2) begin
      n_fail++;
      $display("FAIL rstmid_setup accepts=%0d outstanding=%0d required %0d/2", acc_log.size(), mq.size(), DEPTH);
    end
    rst = 1'b1; mem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || mem_req_valid !== 1'b0 || out_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_state out_valid=%b busy=%b req_valid=%b fault=%b required all 0",
               out_valid, busy, mem_req_valid, out_fault);
    end
    rst = 1'b0;
    model_clear();
    out_pct = 100;
    repeat (10) tick(1'b0, '0);
    n_chk++;
    if (acc_log.size() == 0 || acc_log[0] !== RST_PC || pop_log.size() == 0 || pop_log[0] !== RST_PC) begin
      n_fail++;
      $display("FAIL rstmid_restart accepts=%0d pops=%0d, first request/pop not 80000000", acc_log.size(), pop_log.size());
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    err_hash = 1'b1; lat_min = 1; lat_max = 6;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        req_pct = int'($urandom_range(100, 30));
        out_pct = int'($urandom_range(100, 30));
      end
      r = int'($urandom_range(99));
      if (r < 3) begin
        tick(1'b1, $urandom & 32'hFFFF_FFFC);
        if (r == 0) tick(1'b1, $urandom & 32'hFFFF_FFFC);
      end else begin
        tick(1'b0, '0);
      end
    end
    n_chk++;
    if (pop_log.size() < 200) begin n_fail++; $display("FAIL random_progress pops=%0d required >= 200", pop_log.size()); end
    req_pct = 100; out_pct = 0;
    repeat (40) tick(1'b0, '0);
    n_chk++;
    if (busy !== 1'b0 || mem_req_valid !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_idle busy=%b req_valid=%b out_valid=%b required 0/0/1", busy, mem_req_valid, out_valid);
    end
    err_hash = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_held_redirect();
    test_fault();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
